// File: rtl/mem_responder_if.sv
// Request/response bus between a cache miss path (master) and the
// memory responder (slave). One request outstanding at a time.
interface mem_responder_if #(
  parameter int ADDR_W = 17
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_byte;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;

  modport master (
    output req_valid, req_we, req_byte, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_byte, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory model with fixed response latency.
// Backing store is 2^ADDR_W little-endian bytes, not cleared by reset.
// Stores commit and loads sample the array on the accepting edge; the response
// is presented LATENCY cycles later and held until resp_ready.
// Optional feature macro: MEM_RESPONDER_BYTE_ACCESS_EN enables byte loads
// (zero-extended) and byte stores when req_byte=1. Without it req_byte is
// ignored and every access is an aligned word access.
module mem_responder #(
  parameter int ADDR_W  = 17,
  parameter int LATENCY = 4
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } stateT;

  localparam int          DEPTH    = 1 << ADDR_W;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  // Byte array; deliberately has no reset so contents survive rst.
  logic [7:0] memArray [DEPTH];

  stateT       stateR;
  stateT       stateS;
  logic [3:0]  cntR;
  logic [3:0]  cntS;
  logic [31:0] rdataR;
  logic [31:0] rdataS;

  logic        reqReadyR;
  logic        respValidR;
  logic [31:0] respRdataR;

  logic              acceptS;
  logic              byteModeS;
  logic [ADDR_W-1:0] addr0S;
  logic [ADDR_W-1:0] addr1S;
  logic [ADDR_W-1:0] addr2S;
  logic [ADDR_W-1:0] addr3S;
  logic [31:0]       loadDataS;

  // Assemble a little-endian word from four bytes (byte 0 is least significant).
  function automatic logic [31:0] packWord(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
    packWord = {b3, b2, b1, b0};
  endfunction

`ifdef MEM_RESPONDER_BYTE_ACCESS_EN
  assign byteModeS = bus.req_byte;
`else
  logic unusedReqByteS;
  assign unusedReqByteS = bus.req_byte;
  assign byteModeS      = 1'b0;
`endif

  // Word accesses ignore the low two address bits.
  assign addr0S = {bus.req_addr[ADDR_W-1:2], 2'b00};
  assign addr1S = {bus.req_addr[ADDR_W-1:2], 2'b01};
  assign addr2S = {bus.req_addr[ADDR_W-1:2], 2'b10};
  assign addr3S = {bus.req_addr[ADDR_W-1:2], 2'b11};

  // Gate acceptance with rst so the array cannot be written while reset is held.
  assign acceptS = (stateR == IDLE) && bus.req_valid && rst;

  // Select the load data seen by the array at the accepting edge.
  always_comb begin
    loadDataS = 32'd0;
    if (byteModeS) begin
      loadDataS = {24'd0, memArray[bus.req_addr]};
    end else begin
      loadDataS = packWord(memArray[addr0S], memArray[addr1S],
                           memArray[addr2S], memArray[addr3S]);
    end
  end

  // Next-state, latency counter and response-register logic.
  always_comb begin
    stateS = stateR;
    cntS   = cntR;
    rdataS = rdataR;
    case (stateR)
      IDLE: begin
        if (acceptS) begin
          cntS   = CNT_LOAD;
          rdataS = bus.req_we ? 32'd0 : loadDataS;
          stateS = (LATENCY > 1) ? WAIT : RESP;
        end else begin
          stateS = IDLE;
        end
      end
      WAIT: begin
        if (cntR == 4'd0) begin
          stateS = RESP;
        end else begin
          cntS   = cntR - 4'd1;
          stateS = WAIT;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          stateS = IDLE;
          cntS   = 4'd0;
        end else begin
          stateS = RESP;
        end
      end
      default: begin
        stateS = IDLE;
        cntS   = 4'd0;
        rdataS = 32'd0;
      end
    endcase
  end

  // State, counter, response register and registered bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateR     <= IDLE;
      cntR       <= 4'd0;
      rdataR     <= 32'd0;
      reqReadyR  <= 1'b1;
      respValidR <= 1'b0;
      respRdataR <= 32'd0;
    end else begin
      stateR     <= stateS;
      cntR       <= cntS;
      rdataR     <= rdataS;
      reqReadyR  <= (stateS == IDLE);
      respValidR <= (stateS == RESP);
      respRdataR <= (stateS == RESP) ? rdataS : 32'd0;
    end
  end

  // Commit stores on the accepting edge; only the addressed byte in byte mode.
  always_ff @(posedge clk) begin
    if (acceptS && bus.req_we) begin
      if (byteModeS) begin
        memArray[bus.req_addr] <= bus.req_wdata[7:0];
      end else begin
        memArray[addr0S] <= bus.req_wdata[7:0];
        memArray[addr1S] <= bus.req_wdata[15:8];
        memArray[addr2S] <= bus.req_wdata[23:16];
        memArray[addr3S] <= bus.req_wdata[31:24];
      end
    end
  end

  assign bus.req_ready  = reqReadyR;
  assign bus.resp_valid = respValidR;
  assign bus.resp_rdata = respRdataR;

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder: one instance with LATENCY=4 for the
// main scenarios and one with LATENCY=1 for back-to-back handshaking.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nCmp = 0;
  int   nErr = 0;

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(17)) bus4 ();
  mem_responder_if #(.ADDR_W(17)) bus1 ();

  mem_responder #(.ADDR_W(17), .LATENCY(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  mem_responder #(.ADDR_W(17), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request to dut4 (which must be idle), wait for the response and
  // consume it. Reports cycles from accept to resp_valid and the response data.
  task automatic issue4(input logic we, input logic byt, input logic [16:0] addr,
                        input logic [31:0] wdata, output int lat,
                        output logic [31:0] rdata, output logic zeroOk);
    bus4.req_valid = 1'b1;
    bus4.req_we    = we;
    bus4.req_byte  = byt;
    bus4.req_addr  = addr;
    bus4.req_wdata = wdata;
    step();
    bus4.req_valid = 1'b0;
    lat    = 0;
    zeroOk = 1'b1;
    while (bus4.resp_valid !== 1'b1 && lat < 20) begin
      if (bus4.resp_rdata !== 32'd0) zeroOk = 1'b0;
      step();
      lat++;
    end
    rdata = bus4.resp_rdata;
    bus4.resp_ready = 1'b1;
    step();
    bus4.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus4.req_valid = 1'b0; bus4.req_we = 1'b0; bus4.req_byte = 1'b0;
    bus4.req_addr = 17'd0; bus4.req_wdata = 32'd0; bus4.resp_ready = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_byte = 1'b0;
    bus1.req_addr = 17'd0; bus1.req_wdata = 32'd0; bus1.resp_ready = 1'b0;
    #2 rst = 1'b0;
    step();
    step();
    nCmp++; if (bus4.req_ready !== 1'b1) begin nErr++; $display("FAIL reset_req_ready: got %b want 1", bus4.req_ready); end
    nCmp++; if (bus4.resp_valid !== 1'b0) begin nErr++; $display("FAIL reset_resp_valid: got %b want 0", bus4.resp_valid); end
    nCmp++; if (bus4.resp_rdata !== 32'd0) begin nErr++; $display("FAIL reset_resp_rdata: got %h want 0", bus4.resp_rdata); end
    nCmp++; if (bus1.req_ready !== 1'b1) begin nErr++; $display("FAIL reset_req_ready_lat1: got %b want 1", bus1.req_ready); end
    rst = 1'b1;
    step();
    nCmp++; if (bus4.req_ready !== 1'b1 || bus4.resp_valid !== 1'b0) begin nErr++; $display("FAIL post_reset_idle: got ready=%b valid=%b want 1/0", bus4.req_ready, bus4.resp_valid); end
  endtask

  task automatic test_word_access();
    int lat; logic [31:0] rd; logic zok;
    issue4(1'b1, 1'b0, 17'h100, 32'hDEADBEEF, lat, rd, zok);
    nCmp++; if (lat !== 4) begin nErr++; $display("FAIL store_latency: got %0d want 4", lat); end
    nCmp++; if (rd !== 32'd0) begin nErr++; $display("FAIL store_ack_rdata: got %h want 00000000", rd); end
    issue4(1'b0, 1'b0, 17'h100, 32'd0, lat, rd, zok);
    nCmp++; if (lat !== 4) begin nErr++; $display("FAIL load_latency: got %0d want 4", lat); end
    nCmp++; if (rd !== 32'hDEADBEEF) begin nErr++; $display("FAIL load_word: got %h want deadbeef", rd); end
    nCmp++; if (zok !== 1'b1) begin nErr++; $display("FAIL rdata_zero_in_wait: got nonzero want 0"); end
  endtask

  task automatic test_byte_access();
    int lat; logic [31:0] rd; logic zok; logic [31:0] expWord;
`ifdef MEM_RESPONDER_BYTE_ACCESS_EN
    expWord = 32'h1122A544;
`else
    expWord = 32'h000000A5;
`endif
    issue4(1'b1, 1'b0, 17'h100, 32'h11223344, lat, rd, zok);
    issue4(1'b1, 1'b1, 17'h101, 32'h000000A5, lat, rd, zok);
    nCmp++; if (rd !== 32'd0) begin nErr++; $display("FAIL byte_store_ack: got %h want 00000000", rd); end
    issue4(1'b0, 1'b0, 17'h100, 32'd0, lat, rd, zok);
    nCmp++; if (rd !== expWord) begin nErr++; $display("FAIL word_after_byte_store: got %h want %h", rd, expWord); end
    issue4(1'b0, 1'b1, 17'h101, 32'd0, lat, rd, zok);
    nCmp++; if (rd !== 32'h000000A5) begin nErr++; $display("FAIL byte_load: got %h want 000000a5", rd); end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rd; logic zok;
    issue4(1'b1, 1'b0, 17'h100, 32'hCAFEF00D, lat, rd, zok);
    issue4(1'b0, 1'b0, 17'h103, 32'd0, lat, rd, zok);
    nCmp++; if (rd !== 32'hCAFEF00D) begin nErr++; $display("FAIL misaligned_load: got %h want cafef00d", rd); end
  endtask

  task automatic test_hold();
    int lat; logic [31:0] rd; logic zok; int waitCnt; logic sawValid;
    bus4.req_valid = 1'b1; bus4.req_we = 1'b0; bus4.req_byte = 1'b0;
    bus4.req_addr = 17'h100; bus4.req_wdata = 32'd0;
    step();
    bus4.req_valid = 1'b0;
    waitCnt = 0;
    while (bus4.resp_valid !== 1'b1 && waitCnt < 20) begin step(); waitCnt++; end
    nCmp++; if (bus4.resp_valid !== 1'b1) begin nErr++; $display("FAIL hold_reach_resp: got valid=%b want 1", bus4.resp_valid); end
    for (int i = 0; i < 10; i++) begin
      bus4.req_valid = (i % 2 == 1);
      bus4.req_we    = 1'b1;
      bus4.req_wdata = 32'hBAD0BAD0;
      step();
      nCmp++; if (bus4.resp_valid !== 1'b1 || bus4.resp_rdata !== 32'hCAFEF00D || bus4.req_ready !== 1'b0) begin
        nErr++; $display("FAIL hold_stable[%0d]: got valid=%b rdata=%h ready=%b want 1/cafef00d/0", i, bus4.resp_valid, bus4.resp_rdata, bus4.req_ready);
      end
    end
    bus4.req_valid = 1'b0;
    bus4.resp_ready = 1'b1;
    step();
    bus4.resp_ready = 1'b0;
    nCmp++; if (bus4.resp_valid !== 1'b0 || bus4.req_ready !== 1'b1 || bus4.resp_rdata !== 32'd0) begin
      nErr++; $display("FAIL hold_release: got valid=%b ready=%b rdata=%h want 0/1/0", bus4.resp_valid, bus4.req_ready, bus4.resp_rdata);
    end
    sawValid = 1'b0;
    for (int i = 0; i < 6; i++) begin step(); if (bus4.resp_valid !== 1'b0) sawValid = 1'b1; end
    nCmp++; if (sawValid !== 1'b0) begin nErr++; $display("FAIL hold_no_ghost_accept: got resp_valid want none"); end
    issue4(1'b0, 1'b0, 17'h100, 32'd0, lat, rd, zok);
    nCmp++; if (rd !== 32'hCAFEF00D) begin nErr++; $display("FAIL hold_ignored_store: got %h want cafef00d", rd); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic zok; logic sawValid;
    bus4.req_valid = 1'b1; bus4.req_we = 1'b1; bus4.req_byte = 1'b0;
    bus4.req_addr = 17'h200; bus4.req_wdata = 32'h00000055;
    step();
    bus4.req_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    nCmp++; if (bus4.req_ready !== 1'b1 || bus4.resp_valid !== 1'b0) begin
      nErr++; $display("FAIL reset_mid_immediate: got ready=%b valid=%b want 1/0", bus4.req_ready, bus4.resp_valid);
    end
    sawValid = 1'b0;
    step(); if (bus4.resp_valid !== 1'b0) sawValid = 1'b1;
    step(); if (bus4.resp_valid !== 1'b0) sawValid = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin step(); if (bus4.resp_valid !== 1'b0) sawValid = 1'b1; end
    nCmp++; if (sawValid !== 1'b0) begin nErr++; $display("FAIL reset_mid_aborted: got resp_valid want none"); end
    issue4(1'b0, 1'b0, 17'h200, 32'd0, lat, rd, zok);
    nCmp++; if (lat !== 4) begin nErr++; $display("FAIL reset_mid_load_latency: got %0d want 4", lat); end
    nCmp++; if (rd !== 32'h00000055) begin nErr++; $display("FAIL reset_mid_store_kept: got %h want 00000055", rd); end
  endtask

  task automatic test_back_to_back();
    logic expValid;
    bus1.resp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus1.req_valid = 1'b1;
      bus1.req_we    = 1'b1;
      bus1.req_byte  = 1'b0;
      bus1.req_addr  = 17'(32'h40 + 4 * k);
      bus1.req_wdata = 32'h1000 + 32'(k);
      step();
      expValid = (k % 2 == 0);
      nCmp++; if (bus1.resp_valid !== expValid || bus1.req_ready !== !expValid || bus1.resp_rdata !== 32'd0) begin
        nErr++; $display("FAIL b2b_cycle[%0d]: got valid=%b ready=%b rdata=%h want %b/%b/0", k, bus1.resp_valid, bus1.req_ready, bus1.resp_rdata, expValid, !expValid);
      end
    end
    bus1.req_valid = 1'b1;
    bus1.req_we    = 1'b0;
    bus1.req_addr  = 17'h48;
    step();
    bus1.req_valid = 1'b0;
    nCmp++; if (bus1.resp_valid !== 1'b1 || bus1.resp_rdata !== 32'h00001002) begin
      nErr++; $display("FAIL b2b_load_lat1: got valid=%b rdata=%h want 1/00001002", bus1.resp_valid, bus1.resp_rdata);
    end
    step();
    nCmp++; if (bus1.resp_valid !== 1'b0 || bus1.req_ready !== 1'b1) begin
      nErr++; $display("FAIL b2b_return_idle: got valid=%b ready=%b want 0/1", bus1.resp_valid, bus1.req_ready);
    end
    bus1.resp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_word_access();
    test_byte_access();
    test_misaligned();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
